iq_packet_sched: RTL and testbench

IQ_PACKET_SCHED -- requirements
Module: iq_packet_sched

---
 rtl/iq_packet_sched.sv | 243 ++++++++++++++++++++++++
 tb/tb_iq_packet_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_packet_sched.sv
// IQ packet scheduler: paces a DDS with a decimated clock enable,
// buffers its samples and frames them into fixed-length packets.
module iq_packet_sched #(
  parameter int unsigned DECIM      = 20,
  parameter int unsigned PKT_WORDS  = 256,
  parameter int unsigned FREQ_START = 71582788,
  parameter int unsigned FREQ_STEP  = 1048576,
  parameter int unsigned FREQ_STEPS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        dds_clken,
  output logic [31:0] dds_phi_inc,
  input  logic [31:0] dds_dat,
  input  logic        dds_valid,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  output logic        tx_sop,
  output logic        tx_eop,
  input  logic        tx_ready,
  output logic        busy,
  output logic [15:0] drop_cnt
);

  localparam logic [15:0] LP_DEC_LAST = 16'(DECIM - 1);
  localparam logic [11:0] LP_PKT_LAST = 12'(PKT_WORDS - 1);
  localparam logic [15:0] LP_SWP_LAST = 16'(FREQ_STEPS - 1);
  localparam logic [31:0] LP_START    = 32'(FREQ_START);
  localparam logic [31:0] LP_STEP     = 32'(FREQ_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_dec_cnt;
  logic [11:0] r_enq_cnt;
  logic [11:0] r_deq_cnt;
  logic [15:0] r_swp_idx;
  logic [31:0] r_phi;
  logic [15:0] r_drop;

  logic [31:0] r_mem [16];
  logic [3:0]  r_wr_ptr;
  logic [3:0]  r_rd_ptr;
  logic [4:0]  r_fifo_cnt;

  logic [31:0] r_tx_data;
  logic        r_tx_valid;
  logic        r_tx_sop;
  logic        r_tx_eop;

  logic        w_busy;
  logic        w_clken;
  logic        w_dec_hit;
  logic        w_drained;
  logic        w_in;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic        w_avail;
  logic [3:0]  w_rd_idx;
  logic [11:0] w_deq_nxt;

  assign w_dec_hit = (r_dec_cnt == LP_DEC_LAST);
  assign w_drained = (r_enq_cnt == 12'd0) &&
                     (r_fifo_cnt == 5'd0) &&
                     !r_tx_valid;

  // The head word stays in the FIFO until it is
  // actually transferred, so the output register
  // is a view of the head, not an extra slot.
  assign w_in   = dds_valid && (r_state != S_IDLE);
  assign w_full = (r_fifo_cnt == 5'd16);
  assign w_pop  = r_tx_valid && tx_ready;
  assign w_push = w_in && (!w_full || w_pop);
  assign w_drop = w_in && w_full && !w_pop;

  // Head after this cycle's pop, and its frame index.
  always_comb begin
    w_avail   = 1'b0;
    w_rd_idx  = r_rd_ptr;
    w_deq_nxt = r_deq_cnt;
    if (w_pop) begin
      w_avail  = (r_fifo_cnt > 5'd1);
      w_rd_idx = r_rd_ptr + 4'd1;
      if (r_deq_cnt == LP_PKT_LAST)
        w_deq_nxt = 12'd0;
      else
        w_deq_nxt = r_deq_cnt + 12'd1;
    end else begin
      w_avail = (r_fifo_cnt != 5'd0);
    end
  end

  // FSM next state plus busy and the gated clock enable.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_clken     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable)
          w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_busy  = 1'b1;
        w_clken = w_dec_hit;
        if (!enable)
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_busy  = 1'b1;
        w_clken = w_dec_hit &&
                  (r_enq_cnt != 12'd0);
        if (enable)
          w_state_nxt = S_RUN;
        else if (w_drained)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Decimation counter, parked at zero while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_dec_cnt <= 16'd0;
    else if (r_state == S_IDLE)
      r_dec_cnt <= 16'd0;
    else if (w_dec_hit)
      r_dec_cnt <= 16'd0;
    else
      r_dec_cnt <= r_dec_cnt + 16'd1;
  end

  // Enqueue word counter and per-packet sweep stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enq_cnt <= 12'd0;
      r_swp_idx <= 16'd0;
      r_phi     <= LP_START;
    end else if (w_push) begin
      if (r_enq_cnt == LP_PKT_LAST) begin
        r_enq_cnt <= 12'd0;
        if (r_swp_idx == LP_SWP_LAST) begin
          r_swp_idx <= 16'd0;
          r_phi     <= LP_START;
        end else begin
          r_swp_idx <= r_swp_idx + 16'd1;
          r_phi     <= r_phi + LP_STEP;
        end
      end else begin
        r_enq_cnt <= r_enq_cnt + 12'd1;
      end
    end
  end

  // Saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_drop <= 16'd0;
    else if (w_drop && (r_drop != 16'hFFFF))
      r_drop <= r_drop + 16'd1;
  end

  // FIFO storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= dds_dat;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= 4'd0;
      r_rd_ptr   <= 4'd0;
      r_fifo_cnt <= 5'd0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 4'd1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 4'd1;
      if (w_push && !w_pop)
        r_fifo_cnt <= r_fifo_cnt + 5'd1;
      else if (!w_push && w_pop)
        r_fifo_cnt <= r_fifo_cnt - 5'd1;
    end
  end

  // Dequeue word counter, advancing only on transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_deq_cnt <= 12'd0;
    else
      r_deq_cnt <= w_deq_nxt;
  end

  // Output register: reload on empty slot or transfer,
  // otherwise hold the stalled word and its flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_data  <= 32'd0;
      r_tx_valid <= 1'b0;
      r_tx_sop   <= 1'b0;
      r_tx_eop   <= 1'b0;
    end else if (!r_tx_valid || w_pop) begin
      r_tx_valid <= w_avail;
      if (w_avail) begin
        r_tx_data <= r_mem[w_rd_idx];
        r_tx_sop  <= (w_deq_nxt == 12'd0);
        r_tx_eop  <= (w_deq_nxt == LP_PKT_LAST);
      end else begin
        r_tx_sop  <= 1'b0;
        r_tx_eop  <= 1'b0;
      end
    end
  end

  assign dds_clken   = w_clken;
  assign dds_phi_inc = r_phi;
  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign tx_sop      = r_tx_sop;
  assign tx_eop      = r_tx_eop;
  assign busy        = w_busy;
  assign drop_cnt    = r_drop;

endmodule

// File: tb/tb_iq_packet_sched.sv
// Directed bench for iq_packet_sched: three instances cover
// cadence/drain, framing/sweep/reset and overflow.
`timescale 1ns/1ps
module tb_iq_packet_sched;

  localparam logic [31:0] BASE_B = 32'hB000_0000;
  localparam logic [31:0] BASE_C = 32'hC000_0000;
  localparam logic [31:0] BASE_D = 32'hD000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   vec  = 0;
  int   miss = 0;

  // instance b: framing, sweep, reset mid-packet
  logic        en_b, clken_b, val_b, txv_b, sop_b, eop_b, rdy_b, busy_b;
  logic [31:0] phi_b, dat_b, txd_b, seq_b;
  logic [15:0] drop_b;
  // instance c: overflow
  logic        en_c, clken_c, val_c, txv_c, sop_c, eop_c, rdy_c, busy_c;
  logic [31:0] phi_c, dat_c, txd_c;
  logic [15:0] drop_c;
  // instance d: cadence, drain
  logic        en_d, clken_d, val_d, txv_d, sop_d, eop_d, rdy_d, busy_d;
  logic [31:0] phi_d, dat_d, txd_d, seq_d;
  logic [15:0] drop_d;

  iq_packet_sched #(
    .DECIM(3), .PKT_WORDS(4), .FREQ_START(1000),
    .FREQ_STEP(100), .FREQ_STEPS(2)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b),
    .dds_clken(clken_b), .dds_phi_inc(phi_b),
    .dds_dat(dat_b), .dds_valid(val_b),
    .tx_data(txd_b), .tx_valid(txv_b), .tx_sop(sop_b),
    .tx_eop(eop_b), .tx_ready(rdy_b), .busy(busy_b),
    .drop_cnt(drop_b)
  );

  iq_packet_sched #(
    .DECIM(1), .PKT_WORDS(4)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .enable(en_c),
    .dds_clken(clken_c), .dds_phi_inc(phi_c),
    .dds_dat(dat_c), .dds_valid(val_c),
    .tx_data(txd_c), .tx_valid(txv_c), .tx_sop(sop_c),
    .tx_eop(eop_c), .tx_ready(rdy_c), .busy(busy_c),
    .drop_cnt(drop_c)
  );

  iq_packet_sched #(
    .DECIM(20), .PKT_WORDS(8)
  ) u_d (
    .clk(clk), .rst_n(rst_n), .enable(en_d),
    .dds_clken(clken_d), .dds_phi_inc(phi_d),
    .dds_dat(dat_d), .dds_valid(val_d),
    .tx_data(txd_d), .tx_valid(txv_d), .tx_sop(sop_d),
    .tx_eop(eop_d), .tx_ready(rdy_d), .busy(busy_d),
    .drop_cnt(drop_d)
  );

  // DDS models: answer each clock enable one cycle later
  // with a numbered sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_b <= 1'b0;
      dat_b <= 32'd0;
      seq_b <= 32'd0;
    end else begin
      val_b <= clken_b;
      if (clken_b) begin
        dat_b <= BASE_B + seq_b;
        seq_b <= seq_b + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_d <= 1'b0;
      dat_d <= 32'd0;
      seq_d <= 32'd0;
    end else begin
      val_d <= clken_d;
      if (clken_d) begin
        dat_d <= BASE_D + seq_d;
        seq_d <= seq_d + 32'd1;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en_b = 1'b0; en_c = 1'b0; en_d = 1'b0;
    rdy_b = 1'b0; rdy_c = 1'b0; rdy_d = 1'b0;
    val_c = 1'b0; dat_c = 32'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    vec++; if (txv_b !== 1'b0) begin miss++; $display("FAIL rst_txv got %0b exp 0", txv_b); end
    vec++; if (sop_b !== 1'b0) begin miss++; $display("FAIL rst_sop got %0b exp 0", sop_b); end
    vec++; if (eop_b !== 1'b0) begin miss++; $display("FAIL rst_eop got %0b exp 0", eop_b); end
    vec++; if (txd_b !== 32'd0) begin miss++; $display("FAIL rst_txd got %0h exp 0", txd_b); end
    vec++; if (busy_b !== 1'b0) begin miss++; $display("FAIL rst_busy got %0b exp 0", busy_b); end
    vec++; if (drop_c !== 16'd0) begin miss++; $display("FAIL rst_drop got %0d exp 0", drop_c); end
    vec++; if (phi_b !== 32'd1000) begin miss++; $display("FAIL rst_phi_b got %0d exp 1000", phi_b); end
    vec++; if (phi_d !== 32'd71582788) begin miss++; $display("FAIL rst_phi_d got %0d exp 71582788", phi_d); end
    vec++; if (clken_c !== 1'b0) begin miss++; $display("FAIL rst_clken got %0b exp 0", clken_c); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vec++; if (busy_c !== 1'b0) begin miss++; $display("FAIL idle_busy got %0b exp 0", busy_c); end
    vec++; if (clken_c !== 1'b0) begin miss++; $display("FAIL idle_clken got %0b exp 0", clken_c); end
  endtask

  task automatic test_cadence();
    int p[4];
    int np;
    np = 0;
    do_reset();
    rdy_d = 1'b1;
    en_d = 1'b1;
    for (int cyc = 1; cyc <= 200 && np < 4; cyc++) begin
      @(negedge clk);
      if (clken_d) begin
        p[np] = cyc;
        np++;
        vec++; if (phi_d !== 32'd71582788) begin miss++; $display("FAIL cad_phi got %0d exp 71582788", phi_d); end
      end
    end
    vec++; if (np !== 4) begin miss++; $display("FAIL cad_pulses got %0d exp 4", np); end
    vec++; if (p[0] !== 20) begin miss++; $display("FAIL cad_first got %0d exp 20", p[0]); end
    for (int i = 1; i < np; i++) begin
      vec++; if (p[i] - p[i-1] !== 20) begin miss++; $display("FAIL cad_gap got %0d exp 20", p[i] - p[i-1]); end
    end
    en_d = 1'b0;
  endtask

  task automatic test_framing_sweep();
    logic [31:0] exp_phi [3];
    int nt;
    int lastc;
    exp_phi[0] = 32'd1000;
    exp_phi[1] = 32'd1100;
    exp_phi[2] = 32'd1000;
    nt = 0;
    lastc = 0;
    do_reset();
    rdy_b = 1'b1;
    en_b = 1'b1;
    for (int cyc = 1; cyc <= 300 && nt < 12; cyc++) begin
      @(negedge clk);
      if (txv_b) begin
        vec++; if (txd_b !== BASE_B + 32'(nt)) begin miss++; $display("FAIL frm_data got %0h exp %0h", txd_b, BASE_B + 32'(nt)); end
        vec++; if (sop_b !== (nt % 4 == 0)) begin miss++; $display("FAIL frm_sop word %0d got %0b", nt, sop_b); end
        vec++; if (eop_b !== (nt % 4 == 3)) begin miss++; $display("FAIL frm_eop word %0d got %0b", nt, eop_b); end
        if (nt > 0) begin
          vec++; if (cyc - lastc !== 3) begin miss++; $display("FAIL frm_gap got %0d exp 3", cyc - lastc); end
        end
        if (nt % 4 == 0) begin
          vec++; if (phi_b !== exp_phi[nt/4]) begin miss++; $display("FAIL swp_phi got %0d exp %0d", phi_b, exp_phi[nt/4]); end
        end
        lastc = cyc;
        nt++;
      end
    end
    vec++; if (nt !== 12) begin miss++; $display("FAIL frm_count got %0d exp 12", nt); end
    en_b = 1'b0;
  endtask

  task automatic test_overflow();
    int nt;
    int lastc;
    nt = 0;
    lastc = 0;
    do_reset();
    rdy_c = 1'b0;
    en_c = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      val_c = 1'b1;
      dat_c = BASE_C + 32'(k);
      @(negedge clk);
      if (k == 20) begin
        vec++; if (txd_c !== BASE_C) begin miss++; $display("FAIL ovf_hold_mid got %0h exp %0h", txd_c, BASE_C); end
      end
    end
    val_c = 1'b0;
    vec++; if (drop_c !== 16'd24) begin miss++; $display("FAIL ovf_drop got %0d exp 24", drop_c); end
    vec++; if (txv_c !== 1'b1) begin miss++; $display("FAIL ovf_txv got %0b exp 1", txv_c); end
    vec++; if (txd_c !== BASE_C) begin miss++; $display("FAIL ovf_hold got %0h exp %0h", txd_c, BASE_C); end
    vec++; if (sop_c !== 1'b1) begin miss++; $display("FAIL ovf_sop got %0b exp 1", sop_c); end
    en_c = 1'b0;
    rdy_c = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (txv_c) begin
        vec++; if (txd_c !== BASE_C + 32'(nt)) begin miss++; $display("FAIL ovf_data got %0h exp %0h", txd_c, BASE_C + 32'(nt)); end
        vec++; if (sop_c !== (nt % 4 == 0)) begin miss++; $display("FAIL ovf_sop word %0d got %0b", nt, sop_c); end
        vec++; if (eop_c !== (nt % 4 == 3)) begin miss++; $display("FAIL ovf_eop word %0d got %0b", nt, eop_c); end
        if (nt > 0) begin
          vec++; if (cyc - lastc !== 1) begin miss++; $display("FAIL ovf_b2b got %0d exp 1", cyc - lastc); end
        end
        lastc = cyc;
        nt++;
      end
      @(negedge clk);
    end
    vec++; if (nt !== 16) begin miss++; $display("FAIL ovf_count got %0d exp 16", nt); end
    vec++; if (busy_c !== 1'b0) begin miss++; $display("FAIL ovf_busy got %0b exp 0", busy_c); end
    vec++; if (drop_c !== 16'd24) begin miss++; $display("FAIL ovf_drop_end got %0d exp 24", drop_c); end
  endtask

  task automatic test_drain();
    int nv;
    int nt;
    int npost;
    bit done;
    nv = 0;
    nt = 0;
    npost = 0;
    done = 1'b0;
    do_reset();
    rdy_d = 1'b1;
    en_d = 1'b1;
    for (int cyc = 1; cyc <= 600 && !done; cyc++) begin
      @(negedge clk);
      if (txv_d) begin
        vec++; if (txd_d !== BASE_D + 32'(nt)) begin miss++; $display("FAIL drn_data got %0h exp %0h", txd_d, BASE_D + 32'(nt)); end
        vec++; if (sop_d !== (nt == 0)) begin miss++; $display("FAIL drn_sop word %0d got %0b", nt, sop_d); end
        vec++; if (eop_d !== (nt == 7)) begin miss++; $display("FAIL drn_eop word %0d got %0b", nt, eop_d); end
        nt++;
      end
      if (!en_d && clken_d)
        npost++;
      if (val_d) begin
        nv++;
        if (nv == 5)
          en_d = 1'b0;
      end
      if (!en_d && !busy_d)
        done = 1'b1;
    end
    vec++; if (done !== 1'b1) begin miss++; $display("FAIL drn_timeout got %0b exp 1", done); end
    vec++; if (npost !== 3) begin miss++; $display("FAIL drn_pulses got %0d exp 3", npost); end
    vec++; if (nt !== 8) begin miss++; $display("FAIL drn_words got %0d exp 8", nt); end
    vec++; if (nv !== 8) begin miss++; $display("FAIL drn_samples got %0d exp 8", nv); end
  endtask

  task automatic test_reset_mid();
    int nt;
    bit seen;
    nt = 0;
    seen = 1'b0;
    do_reset();
    rdy_b = 1'b1;
    en_b = 1'b1;
    for (int cyc = 1; cyc <= 200 && nt < 6; cyc++) begin
      @(negedge clk);
      if (txv_b)
        nt++;
    end
    @(negedge clk);
    vec++; if (phi_b !== 32'd1100) begin miss++; $display("FAIL mid_phi_pre got %0d exp 1100", phi_b); end
    rst_n = 1'b0;
    #1;
    vec++; if (txv_b !== 1'b0) begin miss++; $display("FAIL mid_txv got %0b exp 0", txv_b); end
    vec++; if (sop_b !== 1'b0) begin miss++; $display("FAIL mid_sop got %0b exp 0", sop_b); end
    vec++; if (eop_b !== 1'b0) begin miss++; $display("FAIL mid_eop got %0b exp 0", eop_b); end
    vec++; if (txd_b !== 32'd0) begin miss++; $display("FAIL mid_txd got %0h exp 0", txd_b); end
    vec++; if (busy_b !== 1'b0) begin miss++; $display("FAIL mid_busy got %0b exp 0", busy_b); end
    vec++; if (clken_b !== 1'b0) begin miss++; $display("FAIL mid_clken got %0b exp 0", clken_b); end
    vec++; if (phi_b !== 32'd1000) begin miss++; $display("FAIL mid_phi got %0d exp 1000", phi_b); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
      @(negedge clk);
      if (txv_b) begin
        seen = 1'b1;
        vec++; if (sop_b !== 1'b1) begin miss++; $display("FAIL mid_resop got %0b exp 1", sop_b); end
        vec++; if (txd_b !== BASE_B) begin miss++; $display("FAIL mid_redata got %0h exp %0h", txd_b, BASE_B); end
        vec++; if (phi_b !== 32'd1000) begin miss++; $display("FAIL mid_rephi got %0d exp 1000", phi_b); end
      end
    end
    vec++; if (seen !== 1'b1) begin miss++; $display("FAIL mid_timeout got %0b exp 1", seen); end
    en_b = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en_b = 1'b0; en_c = 1'b0; en_d = 1'b0;
    rdy_b = 1'b0; rdy_c = 1'b0; rdy_d = 1'b0;
    val_c = 1'b0; dat_c = 32'd0;
    test_reset();
    test_cadence();
    test_framing_sweep();
    test_overflow();
    test_drain();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
